io_bus_ctrl: RTL and testbench
==============================

Name: io_bus_ctrl

Overview:
- Parametrised, clocked memory-mapped IO bus controller between the CPU data port and NUM_SLV peripheral slots: dmem, VGA text/offset/colour/cursor, keyboard, timer, heap.
- Decodes addr[ADDR_W-1:ADDR_W-SEL_W] against per-slot base selectors.
- Per slot: programmable wait states, one-cycle chip-select/write/read strobes, registered read data.
- Flags and records accesses to unmapped addresses.
- Sits between the CPU load/store unit and the peripherals; successor to the combinational decoder.

Parameters:
- NUM_SLV, 8, number of peripheral slots.
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- SEL_W, 12, width of the decoded top-address field.
- SLV_BASE, {12'h008,12'h007,12'h006,12'h005,12'h004,12'h003,12'h002,12'h001}, packed NUM_SLV*SEL_W; slot i selector at [i*SEL_W +: SEL_W]. Slot 0 = 0x001.
- SLV_WAIT, 0, packed NUM_SLV*4; wait states for slot i at [i*4 +: 4], range 0..15.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req  in  1  master access request; held with addr/we/wdata until ready
- we  in  1  1 = write, 0 = read
- addr  in  ADDR_W  byte address
- wdata  in  DATA_W  write data
- ready  out  1  one-cycle completion pulse
- rdata  out  DATA_W  registered read data, valid while ready=1
- err  out  1  with ready: access was unmapped
- slv_cs  out  NUM_SLV  one-hot chip select during the access cycle
- slv_we  out  NUM_SLV  one-hot write strobe (cs & we)
- slv_rd  out  NUM_SLV  one-hot read strobe (cs & !we), used for side-effect reads such as key pop
- slv_addr  out  ADDR_W  latched address
- slv_wdata  out  DATA_W  latched write data
- slv_rdata  in  NUM_SLV*DATA_W  packed slot read data; slot i at [i*DATA_W +: DATA_W]
- err_cnt  out  8  saturating count of unmapped accesses
- err_addr  out  ADDR_W  address of the most recent unmapped access

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - ready, err, slv_cs, slv_we, slv_rd, rdata, slv_addr, slv_wdata, err_cnt, err_addr all go to 0.
  - Strobes drop immediately, including during WAIT or ACCESS.
  - Any in-flight access is abandoned; no ready is issued.
- FSM states: IDLE, WAIT, ACCESS, RESP.
- IDLE:
  - req sampled only here.
  - On req=1: latch addr, we, wdata. Decode slot = lowest index i with addr[ADDR_W-1 -: SEL_W]==SLV_BASE[i]; overlapping bases resolve to the lowest index.
  - Match with W=SLV_WAIT[slot]>0: go to WAIT, counter := W.
  - Match with W=0: go to ACCESS.
  - No match: go to RESP with err flag; no strobes; err_addr := addr; err_cnt += 1, saturating at 255.
- WAIT: counter decrements each cycle; when counter==1, go to ACCESS. Exactly W cycles spent in WAIT.
- ACCESS (exactly one cycle):
  - slv_cs[slot]=1.
  - slv_we[slot]=we, slv_rd[slot]=!we.
  - At the clock edge, rdata := slv_rdata[slot] on a read; unchanged on a write.
  - Then go to RESP.
- RESP (one cycle): ready=1; err=1 only for unmapped; on unmapped, rdata=0. Then go to IDLE.
- Latency: ready is high in the (W+2)th cycle after the req sampling edge; unmapped accesses take 1 cycle.
- Back-to-back: the minimum gap between accepted requests is 1 IDLE cycle. req still high in IDLE after RESP starts a new access.
- Outputs slv_addr/slv_wdata hold their latched values until the next acceptance.
- Strobes are glitch-free: they are registered outputs, never decoded combinationally from addr.

Test Plan:
- Zero-wait read: SLV_WAIT=0; req, we=0, addr=0x0030_0004, slot1 rdata=0x0000_0041 -> slv_rd=8'h02 for 1 cycle, ready 2 cycles after req edge, rdata=0x41, err=0.
- Waited write: SLV_WAIT slot2=3; we=1, addr=0x0040_0010, wdata=0xDEAD_BEEF -> 3 WAIT cycles, slv_we=8'h04 with slv_wdata=0xDEADBEEF for exactly 1 cycle, ready 5 cycles after req edge.
- Unmapped: addr=0x00A0_0000 -> no strobes, ready+err after 1 cycle, rdata=0, err_addr=0x00A0_0000, err_cnt=1; repeat 300 times -> err_cnt=255.
- Overlap priority: SLV_BASE slots 3 and 5 both 0x009 -> access to 0x0090_0000 asserts only slv_cs[3].
- Reset mid-WAIT: slot wait=10, rst_n low at wait cycle 4 -> strobes, ready, err_cnt all 0 immediately; after release, FSM in IDLE and a new read completes normally.
- Back-to-back: req held high across reads to 0x0070_0000 (timer) then 0x0080_0000 (heap) -> two ready pulses with the correct rdata each, one IDLE cycle between them.

Source files
------------

// File: rtl/io_bus_ctrl.sv
// rtl/io_bus_ctrl.sv - clocked memory-mapped IO bus controller with per-slot wait states
//
// Purpose: sits between the CPU load/store unit and NUM_SLV peripheral slots.
// Decodes the top SEL_W address bits against per-slot base selectors, inserts
// the slot's programmed wait states, issues one-cycle registered strobes and
// returns registered read data with a one-cycle ready pulse. Unmapped accesses
// complete with err and are counted and recorded.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req, we, addr, wdata  master request (held until ready)
//   ready, rdata, err     completion pulse, read data, unmapped flag
//   slv_cs/slv_we/slv_rd  one-hot registered slot strobes
//   slv_addr, slv_wdata   latched address / write data
//   slv_rdata             packed slot read data, slot i at [i*DATA_W +: DATA_W]
//   err_cnt, err_addr     saturating unmapped count, last unmapped address
module io_bus_ctrl #(
  parameter int NUM_SLV = 8,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int SEL_W   = 12,
  parameter logic [NUM_SLV*SEL_W-1:0] SLV_BASE =
    {12'h008, 12'h007, 12'h006, 12'h005, 12'h004, 12'h003, 12'h002, 12'h001},
  parameter logic [NUM_SLV*4-1:0] SLV_WAIT = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req,
  input  logic                       we,
  input  logic [ADDR_W-1:0]          addr,
  input  logic [DATA_W-1:0]          wdata,
  output logic                       ready,
  output logic [DATA_W-1:0]          rdata,
  output logic                       err,
  output logic [NUM_SLV-1:0]         slv_cs,
  output logic [NUM_SLV-1:0]         slv_we,
  output logic [NUM_SLV-1:0]         slv_rd,
  output logic [ADDR_W-1:0]          slv_addr,
  output logic [DATA_W-1:0]          slv_wdata,
  input  logic [NUM_SLV*DATA_W-1:0]  slv_rdata,
  output logic [7:0]                 err_cnt,
  output logic [ADDR_W-1:0]          err_addr
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

  state_t               state, state_nxt;
  logic [3:0]           cnt;
  logic [NUM_SLV-1:0]   slot_q;     // one-hot slot of the access in flight
  logic                 we_q;

  logic [NUM_SLV-1:0]   dec_oh;
  logic [3:0]           dec_wait;
  logic                 dec_hit;
  logic [NUM_SLV-1:0]   sel_oh;
  logic                 sel_we;
  logic [DATA_W-1:0]    rd_mux;
  logic                 accept;

  // Scan from the top down so the lowest matching index wins on overlap.
  always_comb begin
    dec_oh   = '0;
    dec_wait = '0;
    for (int i = NUM_SLV - 1; i >= 0; i--) begin
      if (addr[ADDR_W-1 -: SEL_W] == SLV_BASE[i*SEL_W +: SEL_W]) begin
        dec_oh    = '0;
        dec_oh[i] = 1'b1;
        dec_wait  = SLV_WAIT[i*4 +: 4];
      end
    end
    dec_hit = |dec_oh;
  end

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (slot_q[i]) rd_mux = rd_mux | slv_rdata[i*DATA_W +: DATA_W];
    end
  end

  assign accept = (state == S_IDLE) && req;

  // Strobes are registered from the next state, so the slot selection must
  // come from the decoder on the accepting cycle and from the latch after.
  assign sel_oh = (state == S_IDLE) ? dec_oh : slot_q;
  assign sel_we = (state == S_IDLE) ? we : we_q;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (req) begin
          if (!dec_hit)              state_nxt = S_RESP;
          else if (dec_wait != 4'd0) state_nxt = S_WAIT;
          else                       state_nxt = S_ACCESS;
        end
      end
      S_WAIT:   if (cnt == 4'd1) state_nxt = S_ACCESS;
      S_ACCESS: state_nxt = S_RESP;
      S_RESP:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      slot_q    <= '0;
      we_q      <= 1'b0;
      ready     <= 1'b0;
      err       <= 1'b0;
      rdata     <= '0;
      slv_cs    <= '0;
      slv_we    <= '0;
      slv_rd    <= '0;
      slv_addr  <= '0;
      slv_wdata <= '0;
      err_cnt   <= '0;
      err_addr  <= '0;
    end else begin
      state  <= state_nxt;
      ready  <= (state_nxt == S_RESP);
      err    <= accept && !dec_hit;
      slv_cs <= (state_nxt == S_ACCESS) ? sel_oh : '0;
      slv_we <= (state_nxt == S_ACCESS && sel_we) ? sel_oh : '0;
      slv_rd <= (state_nxt == S_ACCESS && !sel_we) ? sel_oh : '0;

      if (accept) begin
        slv_addr  <= addr;
        slv_wdata <= wdata;
        we_q      <= we;
        slot_q    <= dec_oh;
        cnt       <= dec_wait;
        if (!dec_hit) begin
          err_addr <= addr;
          rdata    <= '0;
          if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end
      end

      if (state == S_WAIT) cnt <= cnt - 4'd1;

      if (state == S_ACCESS && !we_q) rdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_io_bus_ctrl.sv
// tb/tb_io_bus_ctrl.sv - scoreboard testbench for io_bus_ctrl
module tb_io_bus_ctrl;

  localparam logic [95:0] BASES =
    {12'h008, 12'h007, 12'h009, 12'h005, 12'h009, 12'h004, 12'h003, 12'h001};
  localparam logic [31:0] WAITS = 32'h000A_0300; // slot2=3, slot4=10

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req;
  logic         we;
  logic [31:0]  addr;
  logic [31:0]  wdata;
  logic         ready;
  logic [31:0]  rdata;
  logic         err;
  logic [7:0]   slv_cs, slv_we, slv_rd;
  logic [31:0]  slv_addr, slv_wdata;
  logic [255:0] slv_rdata;
  logic [7:0]   err_cnt;
  logic [31:0]  err_addr;

  logic [31:0]  slot_data [8];

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0]  lat;
    logic [7:0]  nstb;
    logic [7:0]  cs;
    logic [7:0]  wes;
    logic [7:0]  rds;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] saddr;
    logic [31:0] swdata;
  } obs_t;

  obs_t exp_q[$];
  logic [31:0] rd_q[$];

  io_bus_ctrl #(
    .NUM_SLV(8), .ADDR_W(32), .DATA_W(32), .SEL_W(12),
    .SLV_BASE(BASES), .SLV_WAIT(WAITS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ready(ready), .rdata(rdata), .err(err),
    .slv_cs(slv_cs), .slv_we(slv_we), .slv_rd(slv_rd),
    .slv_addr(slv_addr), .slv_wdata(slv_wdata), .slv_rdata(slv_rdata),
    .err_cnt(err_cnt), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 8; i++) slv_rdata[i*32 +: 32] = slot_data[i];
  end

  // Drives one access and records what the DUT does until ready (or timeout).
  task automatic run_access(input logic w, input logic [31:0] a,
                            input logic [31:0] d, output obs_t o);
    o = '0;
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk); #1;
      if ((slv_cs | slv_we | slv_rd) != 8'h00) begin
        o.cs     = o.cs | slv_cs;
        o.wes    = o.wes | slv_we;
        o.rds    = o.rds | slv_rd;
        o.nstb   = o.nstb + 8'd1;
        o.saddr  = slv_addr;
        o.swdata = slv_wdata;
      end
      if (ready) begin
        o.lat   = 8'(cyc);
        o.err   = err;
        o.rdata = rdata;
        break;
      end
    end
    req = 1'b0;
    @(negedge clk);
  endtask

  function automatic obs_t mk(input int lat, input int nstb, input logic [7:0] cs,
                              input logic [7:0] wes, input logic [7:0] rds,
                              input logic e, input logic [31:0] rd,
                              input logic [31:0] sa, input logic [31:0] sw);
    obs_t o;
    o.lat = 8'(lat); o.nstb = 8'(nstb); o.cs = cs; o.wes = wes; o.rds = rds;
    o.err = e; o.rdata = rd; o.saddr = sa; o.swdata = sw;
    return o;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({ready, err, slv_cs, slv_we, slv_rd, rdata, slv_addr, slv_wdata, err_cnt, err_addr} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got ready=%b err=%b cs=%h we=%h rd=%h rdata=%h saddr=%h swdata=%h err_cnt=%0d err_addr=%h required all zero",
               ready, err, slv_cs, slv_we, slv_rd, rdata, slv_addr, slv_wdata, err_cnt, err_addr);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset got ready=%b required 0", ready);
    end
  endtask

  task automatic test_zero_wait_read();
    obs_t o, e;
    exp_q.push_back(mk(2, 1, 8'h02, 8'h00, 8'h02, 1'b0, 32'h0000_0041, 32'h0030_0004, 32'h0));
    run_access(1'b0, 32'h0030_0004, 32'h0, o);
    e = exp_q.pop_front();
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL zero_wait_read got %h required %h", o, e);
    end
  endtask

  task automatic test_waited_write();
    obs_t o, e;
    exp_q.push_back(mk(5, 1, 8'h04, 8'h04, 8'h00, 1'b0, 32'h0000_0041, 32'h0040_0010, 32'hDEAD_BEEF));
    run_access(1'b1, 32'h0040_0010, 32'hDEAD_BEEF, o);
    e = exp_q.pop_front();
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL waited_write got %h required %h", o, e);
    end
  endtask

  task automatic test_unmapped();
    obs_t o, e;
    exp_q.push_back(mk(1, 0, 8'h00, 8'h00, 8'h00, 1'b1, 32'h0, 32'h0, 32'h0));
    run_access(1'b0, 32'h00A0_0000, 32'h0, o);
    e = exp_q.pop_front();
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL unmapped_access got %h required %h", o, e);
    end
    checks++;
    if (err_cnt !== 8'd1 || err_addr !== 32'h00A0_0000) begin
      errors++;
      $display("FAIL unmapped_record got cnt=%0d addr=%h required cnt=1 addr=00a00000", err_cnt, err_addr);
    end
    for (int i = 1; i < 300; i++) run_access(1'b0, 32'h00A0_0000 + 32'(i * 4), 32'h0, o);
    checks++;
    if (err_cnt !== 8'd255) begin
      errors++;
      $display("FAIL err_cnt_saturate got %0d required 255", err_cnt);
    end
    checks++;
    if (err_addr !== 32'h00A0_04AC) begin
      errors++;
      $display("FAIL err_addr_latest got %h required 00a004ac", err_addr);
    end
  endtask

  task automatic test_overlap();
    obs_t o, e;
    exp_q.push_back(mk(2, 1, 8'h08, 8'h00, 8'h08, 1'b0, slot_data[3], 32'h0090_0000, 32'h0));
    run_access(1'b0, 32'h0090_0000, 32'h0, o);
    e = exp_q.pop_front();
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL overlap_priority got %h required %h", o, e);
    end
  endtask

  task automatic test_reset_mid_wait();
    obs_t o, e;
    logic early = 1'b0;
    int   late_ready = 0;
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h0050_0000; wdata = '0;
    for (int cyc = 1; cyc <= 4; cyc++) begin
      @(posedge clk); #1;
      if (ready || (slv_cs | slv_we | slv_rd) != 8'h00) early = 1'b1;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (early || ready !== 1'b0 || (slv_cs | slv_we | slv_rd) !== 8'h00 ||
        err_cnt !== 8'd0 || err_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_wait got early=%b ready=%b strobes=%h err_cnt=%0d err_addr=%h required 0",
               early, ready, slv_cs | slv_we | slv_rd, err_cnt, err_addr);
    end
    req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 15; cyc++) begin
      @(posedge clk); #1;
      if (ready || slv_cs != 8'h00) late_ready++;
    end
    checks++;
    if (late_ready != 0) begin
      errors++;
      $display("FAIL abandoned_access got %0d activity cycles required 0", late_ready);
    end
    exp_q.push_back(mk(2, 1, 8'h01, 8'h00, 8'h01, 1'b0, slot_data[0], 32'h0010_0000, 32'h0));
    run_access(1'b0, 32'h0010_0000, 32'h0, o);
    e = exp_q.pop_front();
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL read_after_reset got %h required %h", o, e);
    end
  endtask

  task automatic test_back_to_back();
    int t1 = 0, t2 = 0;
    logic [31:0] exp_rd;
    rd_q.push_back(slot_data[6]);
    rd_q.push_back(slot_data[7]);
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h0070_0000; wdata = '0;
    for (int cyc = 1; cyc <= 40 && t2 == 0; cyc++) begin
      @(posedge clk); #1;
      if (ready) begin
        exp_rd = rd_q.pop_front();
        checks++;
        if (rdata !== exp_rd) begin
          errors++;
          $display("FAIL back_to_back_rdata got %h required %h", rdata, exp_rd);
        end
        if (t1 == 0) begin
          t1 = cyc;
          addr = 32'h0080_0000;
        end else begin
          t2 = cyc;
        end
      end
    end
    req = 1'b0;
    checks++;
    if (t1 != 2 || t2 - t1 != 3) begin
      errors++;
      $display("FAIL back_to_back_timing got first=%0d gap=%0d required first=2 gap=3", t1, t2 - t1);
    end
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) slot_data[i] = 32'h1000_0000 + 32'(i * 32'h111);
    slot_data[1] = 32'h0000_0041;
    test_reset();
    test_zero_wait_read();
    test_waited_write();
    test_unmapped();
    test_overlap();
    test_reset_mid_wait();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
